// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared types and constants for the multi-cycle MIPS controller
package mips_ctrl_pkg;

    // Controller states; encodings 6 and 7 are unreachable and recover to IDLE
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    // Only R-type instructions are executed by this datapath
    localparam logic [5:0] OP_RTYPE = 6'h00;

    // Function codes the ALU control unit understands
    localparam logic [5:0] FN_ADD = 6'd32;
    localparam logic [5:0] FN_SUB = 6'd34;
    localparam logic [5:0] FN_AND = 6'd36;
    localparam logic [5:0] FN_OR  = 6'd37;
    localparam logic [5:0] FN_NOR = 6'd39;
    localparam logic [5:0] FN_SLT = 6'd42;

    // ALUOp codes driven to ALU control
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    // True when the function code is one the ALU can execute
    function automatic logic is_legal_funct(input logic [5:0] funct);
        logic ok;
        case (funct)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_SLT: ok = 1'b1;
            default:                                       ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mips_funct_decode.sv
// rtl/mips_funct_decode.sv - classifies an instruction as a legal R-type operation
module mips_funct_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] Opcode,
    input  logic [5:0] FuncCode,
    output logic       legal
);

    // Legal only when the opcode is R-type and the funct is a supported ALU operation
    always_comb begin
        legal = (Opcode == OP_RTYPE) && is_legal_funct(FuncCode);
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - FETCH/DECODE/EXEC/WB sequencer for the R-type MIPS datapath
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int MAX_INSTR = 6
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [5:0]       Opcode,
    input  logic [5:0]       FuncCode,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic [1:0]       ALUOp,
    output logic             BUSY,
    output logic             HALTED,
    output logic             ILLEGAL,
    output logic [CNT_W-1:0] INSTR_CNT
);

    localparam logic [CNT_W-1:0] BUDGET = CNT_W'(MAX_INSTR);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic             legal;
    logic [CNT_W-1:0] cnt_inc;
    logic             budget_hit;

    mips_funct_decode u_decode (
        .Opcode   (Opcode),
        .FuncCode (FuncCode),
        .legal    (legal)
    );

    // Retirement count after the current WB, saturating at all-ones
    always_comb begin
        cnt_inc    = (&INSTR_CNT) ? INSTR_CNT : INSTR_CNT + ONE;
        budget_hit = (MAX_INSTR != 0) && (cnt_inc == BUDGET);
    end

    // Next-state selection; unreachable encodings fall back to IDLE
    always_comb begin
        state_nxt = S_IDLE;
        case (state)
            S_IDLE:   state_nxt = START ? S_FETCH : S_IDLE;
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: state_nxt = legal ? S_EXEC : S_HALT;
            S_EXEC:   state_nxt = S_WB;
            S_WB:     state_nxt = budget_hit ? S_HALT : S_FETCH;
            S_HALT:   state_nxt = S_HALT;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // State, counter and outputs registered together so outputs track the state being entered
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state     <= S_IDLE;
            PCWrite   <= 1'b0;
            IRWrite   <= 1'b0;
            RegWrite  <= 1'b0;
            ALUOp     <= ALUOP_ADD;
            BUSY      <= 1'b0;
            HALTED    <= 1'b0;
            ILLEGAL   <= 1'b0;
            INSTR_CNT <= '0;
        end else begin
            state    <= state_nxt;
            PCWrite  <= (state_nxt == S_FETCH);
            IRWrite  <= (state_nxt == S_FETCH);
            RegWrite <= (state_nxt == S_WB);
            ALUOp    <= ((state_nxt == S_EXEC) || (state_nxt == S_WB)) ? ALUOP_RTYPE : ALUOP_ADD;
            BUSY     <= (state_nxt == S_FETCH) || (state_nxt == S_DECODE) ||
                        (state_nxt == S_EXEC)  || (state_nxt == S_WB);
            HALTED   <= (state_nxt == S_HALT);
            if ((state == S_DECODE) && !legal) begin
                ILLEGAL <= 1'b1;
            end
            if (state == S_WB) begin
                INSTR_CNT <= cnt_inc;
            end
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - directed scoreboard bench for mips_multicycle_ctrl
module tb_mips_multicycle_ctrl;

    localparam int ST_I = 0;
    localparam int ST_F = 1;
    localparam int ST_D = 2;
    localparam int ST_E = 3;
    localparam int ST_W = 4;
    localparam int ST_H = 5;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       START;
    logic [5:0] Opcode;
    logic [5:0] FuncCode;
    logic       PCWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ALUOp;
    logic       BUSY;
    logic       HALTED;
    logic       ILLEGAL;
    logic [7:0] INSTR_CNT;

    int checks   = 0;
    int failures = 0;
    int cycle_no = 0;
    int rw_count = 0;

    logic [15:0] exp_q[$];

    mips_multicycle_ctrl #(.CNT_W(8), .MAX_INSTR(6)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .START     (START),
        .Opcode    (Opcode),
        .FuncCode  (FuncCode),
        .PCWrite   (PCWrite),
        .IRWrite   (IRWrite),
        .RegWrite  (RegWrite),
        .ALUOp     (ALUOp),
        .BUSY      (BUSY),
        .HALTED    (HALTED),
        .ILLEGAL   (ILLEGAL),
        .INSTR_CNT (INSTR_CNT)
    );

    always #5 CLK = ~CLK;

    // Expected output vector {PCWrite,IRWrite,RegWrite,ALUOp,BUSY,HALTED,ILLEGAL,INSTR_CNT}
    function automatic logic [15:0] ev(input int st, input int cnt, input logic ill);
        logic       pc, ir, rw, busy, hlt;
        logic [1:0] aop;
        logic [7:0] c;
        pc   = (st == ST_F);
        ir   = (st == ST_F);
        rw   = (st == ST_W);
        aop  = ((st == ST_E) || (st == ST_W)) ? 2'b10 : 2'b00;
        busy = (st >= ST_F) && (st <= ST_W);
        hlt  = (st == ST_H);
        c    = cnt[7:0];
        return {pc, ir, rw, aop, busy, hlt, ill, c};
    endfunction

    // One clock: queue the expectation, clock, then pop and compare at the falling edge
    task automatic cyc(input string tag, input int st, input int cnt, input logic ill);
        logic [15:0] e;
        logic [15:0] o;
        exp_q.push_back(ev(st, cnt, ill));
        @(posedge CLK);
        @(negedge CLK);
        cycle_no++;
        e = exp_q.pop_front();
        o = {PCWrite, IRWrite, RegWrite, ALUOp, BUSY, HALTED, ILLEGAL, INSTR_CNT};
        if (RegWrite === 1'b1) rw_count++;
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cycle_no, o, e);
        end
    endtask

    logic [5:0] fn_list[6];

    initial begin
        fn_list = '{6'd32, 6'd36, 6'd34, 6'd37, 6'd42, 6'd39};
        RESET    = 1'b0;
        START    = 1'b1;
        Opcode   = 6'd0;
        FuncCode = 6'd32;

        // Reset held three cycles with START asserted
        for (int i = 0; i < 3; i++) cyc("reset_hold", ST_I, 0, 1'b0);

        // Six legal instructions up to the budget, START toggled while busy
        RESET = 1'b1;
        START = 1'b1;
        for (int k = 0; k < 6; k++) begin
            FuncCode = fn_list[k];
            cyc("fetch", ST_F, k, 1'b0);
            START = 1'($urandom_range(0, 1));
            cyc("decode", ST_D, k, 1'b0);
            START = 1'b1;
            cyc("exec", ST_E, k, 1'b0);
            cyc("wb", ST_W, k, 1'b0);
        end
        cyc("budget_halt", ST_H, 6, 1'b0);
        START = 1'b1;
        for (int i = 0; i < 3; i++) cyc("halt_sticky", ST_H, 6, 1'b0);
        checks++;
        assert (rw_count === 6) else begin
            failures++;
            $error("FAIL regwrite_pulses observed=%0d expected=%0d", rw_count, 6);
        end

        // Illegal funct 33
        RESET = 1'b0;
        START = 1'b0;
        cyc("reset2", ST_I, 0, 1'b0);
        RESET    = 1'b1;
        START    = 1'b1;
        FuncCode = 6'd33;
        cyc("ill_fetch", ST_F, 0, 1'b0);
        START = 1'b0;
        cyc("ill_decode", ST_D, 0, 1'b0);
        cyc("ill_halt", ST_H, 0, 1'b1);
        START = 1'b1;
        cyc("ill_sticky", ST_H, 0, 1'b1);

        // Illegal opcode 2 with a legal funct
        RESET = 1'b0;
        START = 1'b0;
        cyc("reset3", ST_I, 0, 1'b0);
        RESET    = 1'b1;
        START    = 1'b1;
        Opcode   = 6'd2;
        FuncCode = 6'd32;
        cyc("op_fetch", ST_F, 0, 1'b0);
        START = 1'b0;
        cyc("op_decode", ST_D, 0, 1'b0);
        cyc("op_halt", ST_H, 0, 1'b1);
        cyc("op_sticky", ST_H, 0, 1'b1);

        // Reset during EXEC discards the instruction
        RESET = 1'b0;
        cyc("reset4", ST_I, 0, 1'b0);
        RESET  = 1'b1;
        START  = 1'b1;
        Opcode = 6'd0;
        rw_count = 0;
        cyc("mid_fetch", ST_F, 0, 1'b0);
        START = 1'b0;
        cyc("mid_decode", ST_D, 0, 1'b0);
        cyc("mid_exec", ST_E, 0, 1'b0);
        RESET = 1'b0;
        cyc("mid_reset", ST_I, 0, 1'b0);
        RESET = 1'b1;
        cyc("mid_idle1", ST_I, 0, 1'b0);
        cyc("mid_idle2", ST_I, 0, 1'b0);
        checks++;
        assert (rw_count === 0) else begin
            failures++;
            $error("FAIL mid_no_regwrite observed=%0d expected=%0d", rw_count, 0);
        end

        // A fresh instruction after the aborted one still retires normally
        START = 1'b1;
        cyc("re_fetch", ST_F, 0, 1'b0);
        START = 1'b0;
        cyc("re_decode", ST_D, 0, 1'b0);
        cyc("re_exec", ST_E, 0, 1'b0);
        cyc("re_wb", ST_W, 0, 1'b0);
        cyc("re_fetch2", ST_F, 1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
